// File: rtl/led_ctrl_if.sv
// led_ctrl_if: button/LED bundle between the debounced button source and the
// LED controller.
//   btn_up, btn_down, btn_bright, btn_dim : debounced active-high button levels
//   leds   : 4-bit registered LED drive (count bits gated by pwm_on)
//   count  : signed counter value, -8..7
//   level  : brightness level, 0..4
//   pwm_on : registered PWM phase, 1 = LEDs lit
// Modports: master drives the buttons and observes the outputs; slave is the
// controller itself.
interface led_ctrl_if;
  logic              btn_up;
  logic              btn_down;
  logic              btn_bright;
  logic              btn_dim;
  logic [3:0]        leds;
  logic signed [3:0] count;
  logic [2:0]        level;
  logic              pwm_on;

  modport master (
    output btn_up, btn_down, btn_bright, btn_dim,
    input  leds, count, level, pwm_on
  );

  modport slave (
    input  btn_up, btn_down, btn_bright, btn_dim,
    output leds, count, level, pwm_on
  );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: button-driven LED controller.
// Detects press edges on four debounced buttons, keeps a saturating signed
// 4-bit counter (up/down) and a 0..4 brightness level (bright/dim), and shows
// the counter's raw two's-complement bits on four LEDs dimmed by a
// free-running PWM whose duty follows the level (5/25/50/75/100 %).
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : led_ctrl_if.slave (buttons in; leds/count/level/pwm_on out)
// Parameter:
//   PWM_PERIOD : PWM frame length in clk cycles, multiple of 20 and >= 20
module led_ctrl #(
  parameter int PWM_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  led_ctrl_if.slave  bus
);

  localparam int CW   = $clog2(PWM_PERIOD + 1);
  localparam int STEP = PWM_PERIOD / 20;

  localparam logic [CW-1:0] PWM_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] THR_0    = CW'(STEP);
  localparam logic [CW-1:0] THR_1    = CW'(STEP * 5);
  localparam logic [CW-1:0] THR_2    = CW'(STEP * 10);
  localparam logic [CW-1:0] THR_3    = CW'(STEP * 15);
  localparam logic [CW-1:0] THR_4    = CW'(PWM_PERIOD);

  localparam logic signed [3:0] COUNT_MAX = 4'b0111;
  localparam logic signed [3:0] COUNT_MIN = 4'b1000;
  localparam logic [2:0]        LEVEL_MAX = 3'd4;
  localparam logic [2:0]        LEVEL_MIN = 3'd0;

  // Button vector order: 0 = up, 1 = down, 2 = bright, 3 = dim.
  logic [3:0] btn_vec;
  logic [3:0] btn_q_reg;
  logic [3:0] press;

  logic signed [3:0] count_reg, count_next;
  logic [2:0]        level_reg, level_next;
  logic [CW-1:0]     pwm_cnt_reg, pwm_cnt_next;
  logic              pwm_on_reg, pwm_on_next;
  logic [3:0]        leds_reg, leds_next;
  logic [CW-1:0]     thr;

  assign btn_vec = {bus.btn_dim, bus.btn_bright, bus.btn_down, bus.btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      assign press[gi] = btn_vec[gi] & ~btn_q_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next   = count_reg;
    level_next   = level_reg;
    pwm_cnt_next = pwm_cnt_reg + 1'b1;
    thr          = THR_4;

    // Opposing presses in the same cycle cancel.
    if (press[0] && !press[1] && count_reg != COUNT_MAX) begin
      count_next = count_reg + 4'sd1;
    end else if (press[1] && !press[0] && count_reg != COUNT_MIN) begin
      count_next = count_reg - 4'sd1;
    end

    if (press[2] && !press[3] && level_reg != LEVEL_MAX) begin
      level_next = level_reg + 3'd1;
    end else if (press[3] && !press[2] && level_reg != LEVEL_MIN) begin
      level_next = level_reg - 3'd1;
    end

    if (pwm_cnt_reg == PWM_LAST) begin
      pwm_cnt_next = '0;
    end

    // The new level already steers this edge's PWM decision.
    case (level_next)
      3'd0:    thr = THR_0;
      3'd1:    thr = THR_1;
      3'd2:    thr = THR_2;
      3'd3:    thr = THR_3;
      default: thr = THR_4;
    endcase

    pwm_on_next = (pwm_cnt_reg < thr);
    leds_next   = $unsigned(count_next) & {4{pwm_on_next}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // History starts high so a button held through reset is not a press.
      btn_q_reg   <= 4'b1111;
      count_reg   <= 4'sd0;
      level_reg   <= 3'd2;
      pwm_cnt_reg <= '0;
      pwm_on_reg  <= 1'b0;
      leds_reg    <= 4'b0000;
    end else begin
      btn_q_reg   <= btn_vec;
      count_reg   <= count_next;
      level_reg   <= level_next;
      pwm_cnt_reg <= pwm_cnt_next;
      pwm_on_reg  <= pwm_on_next;
      leds_reg    <= leds_next;
    end
  end

  assign bus.count  = count_reg;
  assign bus.level  = level_reg;
  assign bus.pwm_on = pwm_on_reg;
  assign bus.leds   = leds_reg;

endmodule
